// File: rtl/weight_ram_sequencer_pkg.sv
// Shared constants, state encoding and address helper for the weight RAM sequencer.
// The RAM holds NUM_ROWS rows of ROW_LEN words each.
package weight_ram_sequencer_pkg;

    localparam int unsigned DATA_W    = 10;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned ROW_LEN   = 10;
    localparam int unsigned NUM_ROWS  = 3;
    localparam int unsigned RAM_DEPTH = 30;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned ROW_W     = 2;

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StIdle  = 3'd1,
        StRead  = 3'd2,
        StDrain = 3'd3,
        StWrite = 3'd4
    } seq_state_e;

    typedef enum logic {
        GntRead  = 1'b0,
        GntWrite = 1'b1
    } grant_e;

    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
        return ADDR_W'(row * ROW_LEN);
    endfunction

endpackage

// File: rtl/ws_rr_arbiter.sv
// Two-requester round-robin arbiter (read streamer vs. write updater).
// When both request, the one not granted last wins; last_q only moves when take_i is high.
module ws_rr_arbiter
    import weight_ram_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_rd_i,
    input  logic req_wr_i,
    input  logic take_i,
    output logic gnt_rd_o,
    output logic gnt_wr_o
);

    grant_e last_q, last_d;

    always_comb begin
        gnt_rd_o = 1'b0;
        gnt_wr_o = 1'b0;
        if (req_rd_i && req_wr_i) begin
            if (last_q == GntWrite) begin
                gnt_rd_o = 1'b1;
            end else begin
                gnt_wr_o = 1'b1;
            end
        end else begin
            gnt_rd_o = req_rd_i;
            gnt_wr_o = req_wr_i;
        end
    end

    always_comb begin
        last_d = last_q;
        if (take_i) begin
            if (gnt_rd_o) begin
                last_d = GntRead;
            end else if (gnt_wr_o) begin
                last_d = GntWrite;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GntWrite;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/weight_ram_sequencer.sv
// Sole master of the 30x10 weight RAM: init pulse, row-burst streaming to the neuron MAC
// and single-word training writes, arbitrated round-robin.
module weight_ram_sequencer
    import weight_ram_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    input  logic              rd_req,
    input  logic [ROW_W-1:0]  rd_row,
    output logic              rd_ack,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_data,
    output logic [CNT_W-1:0]  w_idx,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              err,
    output logic              busy,
    output logic              ram_in,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(ROW_LEN - 1);

    seq_state_e        state_q, state_d;
    logic              rst_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_ack_q, rd_ack_d;
    logic              wr_ack_q, wr_ack_d;
    logic              err_q, err_d;
    logic              w_valid_q, w_valid_d;
    logic [CNT_W-1:0]  w_idx_q, w_idx_d;
    logic              rd_done_q, rd_done_d;

    logic idle_sample;
    logic take;
    logic gnt_rd, gnt_wr;

    // A rejected request leaves us in IDLE while its ack is still visible; ignore the
    // requester's level for that cycle so it is not granted a second time.
    assign idle_sample = (state_q == StIdle) && !rd_ack_q && !wr_ack_q;
    assign take        = idle_sample && !init_req;

    ws_rr_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_rd_i (rd_req),
        .req_wr_i (wr_req),
        .take_i   (take),
        .gnt_rd_o (gnt_rd),
        .gnt_wr_o (gnt_wr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_ack_d  = 1'b0;
        wr_ack_d  = 1'b0;
        err_d     = 1'b0;
        // Stream strobes are the READ issue strobe/counter delayed by the RAM latency.
        w_valid_d = (state_q == StRead);
        w_idx_d   = (state_q == StRead) ? cnt_q : '0;
        rd_done_d = (state_q == StRead) && (cnt_q == CntLast);

        unique case (state_q)
            StInit: begin
                state_d = rst_q ? StInit : StIdle;
            end
            StIdle: begin
                if (idle_sample) begin
                    if (init_req) begin
                        state_d = StInit;
                    end else if (gnt_rd) begin
                        rd_ack_d = 1'b1;
                        if (rd_row >= ROW_W'(NUM_ROWS)) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = StRead;
                            base_d  = row_base(rd_row);
                            cnt_d   = '0;
                        end
                    end else if (gnt_wr) begin
                        wr_ack_d = 1'b1;
                        if (wr_addr >= ADDR_W'(RAM_DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            state_d   = StWrite;
                            wr_addr_d = wr_addr;
                            wr_data_d = wr_data;
                        end
                    end
                end
            end
            StRead: begin
                if (cnt_q == CntLast) begin
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDrain: begin
                state_d = StIdle;
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            w_valid_q <= 1'b0;
            w_idx_q   <= '0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
            err_q     <= err_d;
            w_valid_q <= w_valid_d;
            w_idx_q   <= w_idx_d;
            rd_done_q <= rd_done_d;
        end
    end

    // RAM pins decode only registered state; INIT is held silent while reset is still seen.
    always_comb begin
        ram_in   = (state_q == StInit) && !rst_q;
        ram_we   = (state_q == StWrite);
        ram_addr = '0;
        ram_d    = '0;
        if (state_q == StRead) begin
            ram_addr = base_q + ADDR_W'(cnt_q);
        end else if (state_q == StWrite) begin
            ram_addr = wr_addr_q;
            ram_d    = wr_data_q;
        end
    end

    assign busy    = (state_q != StIdle) && !rst_q;
    assign rd_ack  = rd_ack_q;
    assign wr_ack  = wr_ack_q;
    assign err     = err_q;
    assign w_valid = w_valid_q;
    assign w_idx   = w_idx_q;
    assign rd_done = rd_done_q;
    assign w_data  = w_valid_q ? ram_q : '0;

endmodule

// File: tb/tb_weight_ram_sequencer.sv
// Self-checking bench for weight_ram_sequencer with a behavioural 1-cycle-latency RAM and a
// scoreboard of expected streamed words.
module tb_weight_ram_sequencer;
    import weight_ram_sequencer_pkg::*;

    typedef struct packed {
        logic [3:0] idx;
        logic [9:0] data;
        logic       done;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_req = 1'b0;
    logic       rd_req = 1'b0;
    logic [1:0] rd_row = 2'd0;
    logic       wr_req = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [9:0] wr_data = 10'd0;
    logic [9:0] ram_q = 10'd0;
    logic       rd_ack, w_valid, rd_done, wr_ack, err, busy, ram_in, ram_we;
    logic [9:0] w_data, ram_d;
    logic [3:0] w_idx;
    logic [4:0] ram_addr;

    always #5 clk = ~clk;

    weight_ram_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .init_req (init_req),
        .rd_req   (rd_req),
        .rd_row   (rd_row),
        .rd_ack   (rd_ack),
        .w_valid  (w_valid),
        .w_data   (w_data),
        .w_idx    (w_idx),
        .rd_done  (rd_done),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .err      (err),
        .busy     (busy),
        .ram_in   (ram_in),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_d    (ram_d),
        .ram_q    (ram_q)
    );

    function automatic logic [9:0] init_word(input int a);
        if (a < 10) return 10'b0011001100;
        else if (a < 20) return 10'b0101010101;
        else return 10'b1111100000;
    endfunction

    logic [9:0] ram_mem [30];
    always @(posedge clk) begin
        if (ram_in) begin
            for (int i = 0; i < 30; i++) ram_mem[i] <= init_word(i);
        end else if (ram_we && ram_addr < 5'd30) begin
            ram_mem[ram_addr] <= ram_d;
        end
        ram_q <= (ram_addr < 5'd30) ? ram_mem[ram_addr] : 10'd0;
    end

    int   both_hi = 0, we_seen = 0, we_in_burst = 0;
    logic in_burst = 1'b0;
    always @(negedge clk) begin
        if (ram_we && ram_in) both_hi <= both_hi + 1;
        if (ram_we) we_seen <= we_seen + 1;
        if (ram_we && in_burst) we_in_burst <= we_in_burst + 1;
        if (rst || rd_done) in_burst <= 1'b0;
        else if (rd_ack && !err) in_burst <= 1'b1;
    end

    int         n_checks = 0, n_fail = 0;
    beat_t      exp_q[$];
    logic [9:0] ref_mem [30];

    task automatic ref_init();
        for (int i = 0; i < 30; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic push_row(input int row);
        for (int i = 0; i < 10; i++) exp_q.push_back({4'(i), ref_mem[row*10+i], i == 9});
    endtask

    task automatic do_read(input int row);
        bit    ok;
        int    quiet;
        beat_t e;
        ok = 1'b0;
        rd_row = row[1:0];
        rd_req = 1'b1;
        if (row < 3) push_row(row);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rd_ack === 1'b1) begin ok = 1'b1; break; end
        end
        rd_req = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rd_grant_timeout row=%0d: rd_ack got 0 required 1", row);
            exp_q.delete();
            return;
        end
        n_checks++;
        if (err !== (row >= 3)) begin
            n_fail++;
            $display("FAIL rd_err row=%0d: err got %b required %b", row, err, row >= 3);
        end
        if (row >= 3) begin
            quiet = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (w_valid !== 1'b0 || rd_done !== 1'b0) quiet++;
            end
            n_checks++;
            if (quiet != 0) begin
                n_fail++;
                $display("FAIL rd_reject_quiet: stream cycles got %0d required 0", quiet);
            end
            return;
        end
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 10) begin
                n_checks++;
                if (ram_addr !== 5'(row*10+k) || ram_we !== 1'b0 || ram_in !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rd_addr k=%0d: addr/we/in got %0d/%b/%b required %0d/0/0",
                             k, ram_addr, ram_we, ram_in, row*10+k);
                end
            end
            if (k > 0) begin
                n_checks++;
                if (w_valid !== 1'b1 || exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_beat_valid k=%0d: w_valid got %b required 1", k, w_valid);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if ({w_idx, w_data, rd_done} !== {e.idx, e.data, e.done}) begin
                        n_fail++;
                        $display("FAIL rd_beat row=%0d: idx/data/done got %0d/%b/%b required %0d/%b/%b",
                                 row, w_idx, w_data, rd_done, e.idx, e.data, e.done);
                    end
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (w_valid !== 1'b0 || rd_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_end: w_valid/rd_done got %b/%b required 0/0", w_valid, rd_done);
        end
    endtask

    task automatic do_write(input int addr, input logic [9:0] data);
        bit ok;
        ok = 1'b0;
        wr_addr = addr[4:0];
        wr_data = data;
        wr_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wr_ack === 1'b1) begin ok = 1'b1; break; end
        end
        wr_req = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wr_grant_timeout addr=%0d: wr_ack got 0 required 1", addr);
            return;
        end
        n_checks++;
        if (err !== (addr >= 30) || ram_we !== (addr < 30)) begin
            n_fail++;
            $display("FAIL wr_issue addr=%0d: err/ram_we got %b/%b required %b/%b",
                     addr, err, ram_we, addr >= 30, addr < 30);
        end
        if (addr < 30) begin
            n_checks++;
            if (ram_addr !== addr[4:0] || ram_d !== data || ram_in !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_pins: addr/d/in got %0d/%b/%b required %0d/%b/0",
                         ram_addr, ram_d, ram_in, addr, data);
            end
            ref_mem[addr] = data;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int pulses, we_base;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ram_in, ram_we, busy, w_valid, rd_ack, wr_ack, err, rd_done} !== 8'd0 ||
            ram_addr !== 5'd0 || ram_d !== 10'd0 || w_idx !== 4'd0 || w_data !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctl=%b addr=%0d d=%0d required all 0",
                     {ram_in, ram_we, busy, w_valid, rd_ack, wr_ack, err, rd_done}, ram_addr, ram_d);
        end
        we_base = we_seen;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ram_in !== 1'b1 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL init_pulse: ram_in/ram_we got %b/%b required 1/0", ram_in, ram_we);
        end
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ram_in !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_once: extra ram_in cycles %0d busy %b required 0/0", pulses, busy);
        end
        n_checks++;
        if (we_seen != we_base) begin
            n_fail++;
            $display("FAIL init_no_we: ram_we cycles got %0d required 0", we_seen - we_base);
        end
        ref_init();
    endtask

    task automatic test_stream();
        do_read(1);
    endtask

    task automatic test_write_then_read();
        do_write(22, 10'b0000011111);
        do_read(2);
    endtask

    // Entered with the read side granted last, so the write wins the first tie.
    task automatic test_round_robin();
        int    acks, burst_base;
        bit    want_wr;
        beat_t e;
        acks = 0;
        want_wr = 1'b1;
        burst_base = we_in_burst;
        rd_row = 2'd0;
        wr_addr = 5'd5;
        wr_data = 10'h2aa;
        rd_req = 1'b1;
        wr_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (w_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr_beat_extra: w_valid got 1 required 0");
                end else begin
                    e = exp_q.pop_front();
                    if ({w_idx, w_data, rd_done} !== {e.idx, e.data, e.done}) begin
                        n_fail++;
                        $display("FAIL rr_beat: idx/data/done got %0d/%b/%b required %0d/%b/%b",
                                 w_idx, w_data, rd_done, e.idx, e.data, e.done);
                    end
                end
            end
            if (wr_ack === 1'b1) begin
                n_checks++;
                if (want_wr !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr_order ack#%0d: got write required read", acks);
                end
                ref_mem[5] = wr_data;
                wr_data = 10'h0f3;
                want_wr = 1'b0;
                acks++;
            end
            if (rd_ack === 1'b1) begin
                n_checks++;
                if (want_wr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_order ack#%0d: got read required write", acks);
                end
                push_row(0);
                want_wr = 1'b1;
                acks++;
            end
            if (acks >= 4) begin
                rd_req = 1'b0;
                wr_req = 1'b0;
                if (exp_q.size() == 0) break;
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        n_checks++;
        if (acks != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_progress: acks %0d pending beats %0d required 4/0", acks, exp_q.size());
        end
        exp_q.delete();
        n_checks++;
        if (we_in_burst != burst_base) begin
            n_fail++;
            $display("FAIL rr_write_in_burst: got %0d required 0", we_in_burst - burst_base);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_errors();
        int we_base;
        we_base = we_seen;
        do_read(3);
        do_write(30, 10'h155);
        @(negedge clk);
        n_checks++;
        if (we_seen != we_base || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_we: ram_we cycles %0d busy %b required 0/0", we_seen - we_base, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit    ok;
        int    bad;
        beat_t e;
        ok = 1'b0;
        rd_row = 2'd1;
        rd_req = 1'b1;
        push_row(1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rd_ack === 1'b1) begin ok = 1'b1; break; end
        end
        rd_req = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_grant_timeout: rd_ack got 0 required 1");
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (w_valid === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (w_idx === 4'd4) begin ok = 1'b1; break; end
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_reach_idx4: w_idx 4 got unseen required seen");
        end
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (w_valid !== 1'b0 || rd_done !== 1'b0 || ram_in !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_drop: w_valid/rd_done/ram_in got %b/%b/%b required 0/0/0",
                     w_valid, rd_done, ram_in);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ram_in !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reinit: ram_in got %b required 1", ram_in);
        end
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (w_valid !== 1'b0 || rd_done !== 1'b0 || ram_in !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mid_quiet: stray cycles got %0d required 0", bad);
        end
        ref_init();

        // init_req raised mid-burst must wait for DRAIN, then IDLE, then INIT.
        ok = 1'b0;
        bad = 0;
        rd_row = 2'd2;
        rd_req = 1'b1;
        push_row(2);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rd_ack === 1'b1) begin ok = 1'b1; break; end
        end
        rd_req = 1'b0;
        for (int c = 0; c < 20 && ok; c++) begin
            @(negedge clk);
            if (ram_in !== 1'b0) bad++;
            if (w_valid === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({w_idx, w_data, rd_done} !== {e.idx, e.data, e.done}) begin
                    n_fail++;
                    $display("FAIL init_burst_beat: idx/data/done got %0d/%b/%b required %0d/%b/%b",
                             w_idx, w_data, rd_done, e.idx, e.data, e.done);
                end
                if (e.idx == 4'd2) init_req = 1'b1;
                if (e.done) break;
            end
        end
        n_checks++;
        if (!ok || exp_q.size() != 0 || bad != 0) begin
            n_fail++;
            $display("FAIL init_defer: granted %b left %0d early ram_in %0d required 1/0/0",
                     ok, exp_q.size(), bad);
        end
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (ram_in !== 1'b0) begin
            n_fail++;
            $display("FAIL init_after_drain_idle: ram_in got %b required 0", ram_in);
        end
        @(negedge clk);
        n_checks++;
        if (ram_in !== 1'b1 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL init_after_drain: ram_in/ram_we got %b/%b required 1/0", ram_in, ram_we);
        end
        init_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ram_in !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_done: ram_in/busy got %b/%b required 0/0", ram_in, busy);
        end
        ref_init();
        do_read(2);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_write_then_read();
        test_round_robin();
        test_errors();
        test_reset_mid_burst();
        n_checks++;
        if (both_hi != 0) begin
            n_fail++;
            $display("FAIL we_in_exclusive: overlap cycles got %0d required 0", both_hi);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
